// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and helpers for the posted-write store buffer
//
// Provides the word-address width, the buffered entry layout and a clog2
// helper used to size the FIFO pointers and the occupancy count.
package store_buffer_pkg;

    localparam int WORD_ADDR_W = 30;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [31:0]            data;
    } sb_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - youngest-entry address match search over the store FIFO
//
// Ports:
//   entries  in   FIFO storage (all DEPTH slots, valid or not)
//   head     in   index of the oldest valid entry
//   count    in   number of valid entries
//   word     in   word address being looked up
//   hit      out  at least one valid entry holds this word address
//   data     out  data of the youngest matching valid entry (0 when no hit)
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  sb_entry_t              entries [DEPTH],
    input  logic [PTR_W-1:0]       head,
    input  logic [CNT_W-1:0]       count,
    input  logic [WORD_ADDR_W-1:0] word,
    output logic                   hit,
    output logic [31:0]            data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest; a later match overwrites an earlier one,
    // so the youngest matching store wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == word)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store FIFO sharing the data memory port with loads
//
// Stores are queued and retired one per cycle whenever no load owns the
// memory port. Loads have priority on the port.
// Build option STORE_BUF_FWD_EN: when defined, loads take data from the
// youngest buffered store to the same word; when undefined, such loads stall
// (ld_stall=1) while the buffer drains until no buffered entry matches.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready    store handshake; st_addr (byte address), st_data
//   ld_en, ld_addr       load request (byte address); ld_data result
//   ld_stall             load cannot complete this cycle
//   empty                no stores pending
//   mem_WE/mem_addr/mem_WD/mem_RD  single-port data memory, combinational read
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    output logic        empty,
    output logic        mem_WE,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    sb_entry_t        entries [DEPTH];
    sb_entry_t        head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             hit;
    logic [31:0]      fwd_data;
    logic             load_active;
    logic             drain;
    logic             enq;

    store_buffer_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .word    (ld_addr[31:2]),
        .hit     (hit),
        .data    (fwd_data)
    );

    // Byte-offset bits of the addresses are ignored by design.
    logic unused_bits;

`ifdef STORE_BUF_FWD_EN
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
    assign ld_stall    = 1'b0;
    assign load_active = ld_en;
    assign ld_data     = !ld_en ? 32'd0 : (hit ? fwd_data : mem_RD);
`else
    // Without forwarding a matching load yields the port so the buffer can
    // drain the conflicting entries; it completes once nothing matches.
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], fwd_data};
    assign ld_stall    = ld_en && hit;
    assign load_active = ld_en && !hit;
    assign ld_data     = load_active ? mem_RD : 32'd0;
`endif

    assign head_entry = entries[head];
    assign st_ready   = (count != FULL_COUNT);
    assign empty      = (count == '0);
    assign enq        = st_valid && st_ready;
    assign drain      = !load_active && (count != '0);

    assign mem_WE   = drain;
    assign mem_WD   = drain ? head_entry.data : 32'd0;
    assign mem_addr = load_active ? ld_addr
                    : drain       ? {head_entry.addr, 2'b00}
                    :               32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately not reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= {st_addr[31:2], st_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer with a queue-based reference model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        st_ready, ld_stall, empty, mem_WE;
    logic [31:0] ld_data, mem_addr, mem_WD, mem_RD;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } pend_t;
    pend_t pend[$];

    int checks = 0;
    int failures = 0;

    logic        exp_ready, exp_empty, exp_stall, exp_we, exp_drain;
    logic [31:0] exp_ld, exp_addr, exp_wd;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .empty    (empty),
        .mem_WE   (mem_WE),
        .mem_addr (mem_addr),
        .mem_WD   (mem_WD),
        .mem_RD   (mem_RD)
    );

    assign mem_RD = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_WE) mem[mem_addr[11:2]] <= mem_WD;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic void model_eval();
        int hit_i;
        hit_i = -1;
        for (int i = 0; i < pend.size(); i++)
            if (pend[i].a == ld_addr[31:2]) hit_i = i;
        exp_ready = (pend.size() < DEPTH);
        exp_empty = (pend.size() == 0);
        exp_stall = 1'b0;
        exp_ld    = '0;
        exp_drain = 1'b0;
        if (ld_en) begin
`ifdef STORE_BUF_FWD_EN
            if (hit_i >= 0) exp_ld = pend[hit_i].d;
            else            exp_ld = ref_mem[ld_addr[11:2]];
`else
            if (hit_i >= 0) begin
                exp_stall = 1'b1;
                exp_drain = 1'b1;
            end else begin
                exp_ld = ref_mem[ld_addr[11:2]];
            end
`endif
        end else begin
            exp_drain = (pend.size() != 0);
        end
        exp_we   = exp_drain;
        exp_wd   = '0;
        exp_addr = ld_en ? ld_addr : 32'd0;
        if (exp_drain) begin
            exp_wd   = pend[0].d;
            exp_addr = {pend[0].a, 2'b00};
        end
    endfunction

    task automatic setin(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic le, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_en    = le;
        ld_addr  = la;
        #1;
        model_eval();
    endtask

    task automatic tick();
        pend_t e;
        if (exp_drain) begin
            ref_mem[pend[0].a[9:0]] = pend[0].d;
            void'(pend.pop_front());
        end
        if (st_valid && exp_ready) begin
            e.a = st_addr[31:2];
            e.d = st_data;
            pend.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (st_ready !== 1'b1 || empty !== 1'b1 || mem_WE !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b empty=%b we=%b stall=%b ld=%h exp 1 1 0 0 0",
                     st_ready, empty, mem_WE, ld_stall, ld_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        setin(0, 0, 0, 0, 0);
        checks++;
        if (st_ready !== 1'b1 || empty !== 1'b1 || mem_WE !== 1'b0 || mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_idle got rdy=%b empty=%b we=%b addr=%h exp 1 1 0 0",
                     st_ready, empty, mem_WE, mem_addr);
        end
    endtask

    task automatic test_drain3();
        logic [31:0] a [3];
        logic [31:0] d [3];
        a[0] = 32'h10; a[1] = 32'h14; a[2] = 32'h18;
        d[0] = 32'hA;  d[1] = 32'hB;  d[2] = 32'hC;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) setin(1, a[c], d[c], 0, 0);
            else       setin(0, 0, 0, 0, 0);
            checks++;
            if (mem_WE !== (c > 0)) begin
                failures++;
                $display("FAIL drain3_we cycle=%0d got=%b exp=%b", c, mem_WE, c > 0);
            end
            if (c > 0) begin
                checks++;
                if (mem_addr !== a[c-1] || mem_WD !== d[c-1]) begin
                    failures++;
                    $display("FAIL drain3_write cycle=%0d got addr=%h wd=%h exp addr=%h wd=%h",
                             c, mem_addr, mem_WD, a[c-1], d[c-1]);
                end
            end
            tick();
        end
        setin(0, 0, 0, 0, 0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL drain3_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 5; k++) begin
            setin(1, 32'h200 + 32'(4 * k), 32'h5000 + 32'(k), 1, 32'h100);
            checks++;
            if (st_ready !== (k < 4) || mem_WE !== 1'b0 || ld_data !== 32'hBE00_0040) begin
                failures++;
                $display("FAIL full_fill k=%0d got rdy=%b we=%b ld=%h exp rdy=%b we=0 ld=be000040",
                         k, st_ready, mem_WE, ld_data, k < 4);
            end
            tick();
        end
        for (int r = 0; r < 5; r++) begin
            if (r < 2) setin(1, 32'h210, 32'h5004, 0, 0);
            else       setin(0, 0, 0, 0, 0);
            if (r < 2) begin
                checks++;
                if (st_ready !== (r == 1)) begin
                    failures++;
                    $display("FAIL full_ready r=%0d got=%b exp=%b", r, st_ready, r == 1);
                end
            end
            checks++;
            if (mem_WE !== 1'b1 || mem_addr !== 32'h200 + 32'(4 * r) || mem_WD !== 32'h5000 + 32'(r)) begin
                failures++;
                $display("FAIL full_order r=%0d got we=%b addr=%h wd=%h exp we=1 addr=%h wd=%h",
                         r, mem_WE, mem_addr, mem_WD, 32'h200 + 32'(4 * r), 32'h5000 + 32'(r));
            end
            tick();
        end
        setin(0, 0, 0, 0, 0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL full_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_forward();
        setin(1, 32'h20, 32'h1111, 1, 32'h300);
        tick();
        setin(1, 32'h20, 32'h2222, 1, 32'h300);
        tick();
`ifdef STORE_BUF_FWD_EN
        setin(0, 0, 0, 1, 32'h22);
        checks++;
        if (ld_data !== 32'h2222 || ld_stall !== 1'b0 || mem_WE !== 1'b0) begin
            failures++;
            $display("FAIL fwd_load got ld=%h stall=%b we=%b exp ld=2222 stall=0 we=0",
                     ld_data, ld_stall, mem_WE);
        end
        tick();
`else
        for (int c = 0; c < 2; c++) begin
            setin(0, 0, 0, 1, 32'h22);
            checks++;
            if (ld_stall !== 1'b1 || ld_data !== 32'd0 || mem_WE !== 1'b1 ||
                mem_WD !== (c == 0 ? 32'h1111 : 32'h2222)) begin
                failures++;
                $display("FAIL nofwd_stall c=%0d got stall=%b ld=%h we=%b wd=%h exp stall=1 ld=0 we=1 wd=%h",
                         c, ld_stall, ld_data, mem_WE, mem_WD, (c == 0 ? 32'h1111 : 32'h2222));
            end
            tick();
        end
        setin(0, 0, 0, 1, 32'h22);
        checks++;
        if (ld_stall !== 1'b0 || ld_data !== 32'h2222 || mem_WE !== 1'b0) begin
            failures++;
            $display("FAIL nofwd_release got stall=%b ld=%h we=%b exp stall=0 ld=2222 we=0",
                     ld_stall, ld_data, mem_WE);
        end
        tick();
`endif
        setin(0, 0, 0, 0, 0);
        tick();
        setin(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_no_match();
        setin(1, 32'h44, 32'h4444, 1, 32'h300);
        tick();
        setin(0, 0, 0, 1, 32'h40);
        checks++;
        if (ld_data !== 32'hBE00_0010 || mem_WE !== 1'b0 || ld_stall !== 1'b0 || mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL nomatch_load got ld=%h we=%b stall=%b addr=%h exp ld=be000010 we=0 stall=0 addr=40",
                     ld_data, mem_WE, ld_stall, mem_addr);
        end
        tick();
        setin(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_old [3];
        exp_old[0] = 32'hA; exp_old[1] = 32'hB; exp_old[2] = 32'hC;
        for (int k = 0; k < 3; k++) begin
            setin(1, 32'h10 + 32'(4 * k), 32'hF1 + 32'(k), 1, 32'h300);
            tick();
        end
        setin(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || st_ready !== 1'b1 || mem_WE !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got empty=%b rdy=%b we=%b exp 1 1 0", empty, st_ready, mem_WE);
        end
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setin(0, 0, 0, 1, 32'h10 + 32'(4 * k));
            checks++;
            if (ld_data !== exp_old[k]) begin
                failures++;
                $display("FAIL midreset_old k=%0d got=%h exp=%h", k, ld_data, exp_old[k]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
            setin(1'($urandom % 2),
                  32'h80 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom % 4),
                  $urandom,
                  1'(($urandom % 10) < 4),
                  32'h80 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom % 4));
            checks++;
            if (st_ready !== exp_ready || empty !== exp_empty) begin
                failures++;
                $display("FAIL rand_status n=%0d got rdy=%b empty=%b exp rdy=%b empty=%b",
                         n, st_ready, empty, exp_ready, exp_empty);
            end
            checks++;
            if (ld_stall !== exp_stall || ld_data !== exp_ld) begin
                failures++;
                $display("FAIL rand_load n=%0d got stall=%b ld=%h exp stall=%b ld=%h",
                         n, ld_stall, ld_data, exp_stall, exp_ld);
            end
            checks++;
            if (mem_WE !== exp_we || mem_addr !== exp_addr || mem_WD !== exp_wd) begin
                failures++;
                $display("FAIL rand_port n=%0d got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                         n, mem_WE, mem_addr, mem_WD, exp_we, exp_addr, exp_wd);
            end
            tick();
        end
        for (int k = 0; k <= DEPTH; k++) begin
            setin(0, 0, 0, 0, 0);
            tick();
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_memory got mismatching_words=%0d exp=0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hBE00_0000 | 32'(i);
            ref_mem[i] = 32'hBE00_0000 | 32'(i);
        end
        mem[8]     = 32'd0;
        ref_mem[8] = 32'd0;
        test_reset();
        test_drain3();
        test_full();
        test_forward();
        test_no_match();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the core's load/store path and the single-port word-addressed data memory. Stores are accepted into a small FIFO and retired to memory one word per cycle whenever the memory port is not needed for a load. Loads read memory directly, and take data forwarded from the youngest buffered store to the same word address when one exists. This decouples store completion from memory port availability, a prerequisite for the multi-cycle and pipelined cores.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- st_valid  in  1  core presents a store
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  store byte address; bits [1:0] ignored
- st_data  in  32  store word
- ld_en  in  1  core performs a load this cycle
- ld_addr  in  32  load byte address; bits [1:0] ignored
- ld_data  out  32  load result
- ld_stall  out  1  load cannot complete this cycle; core must hold
- empty  out  1  no pending stores
- mem_WE  out  1  write enable to data memory
- mem_addr  out  32  address to data memory
- mem_WD  out  32  write data to data memory
- mem_RD  in  32  combinational read data from data memory

## Operation
- State: DEPTH entries of {word address [31:2], data [31:0]}, head pointer, tail pointer, and an occupancy count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Enqueue: st_valid && st_ready at a rising edge writes {st_addr[31:2], st_data} at tail, tail+1, count+1.
- st_ready = (count != DEPTH). It is combinational from count only. A drain in the same cycle does not free a slot for the current cycle.
- Port arbitration, combinational, with loads having priority:
  - ld_en=1: mem_addr=ld_addr, mem_WE=0, no drain.
  - ld_en=0 and count>0: mem_addr={head addr,2'b00}, mem_WD=head data, mem_WE=1. The rising edge retires the entry: head+1, count-1.
  - Otherwise: mem_WE=0, mem_addr=0, mem_WD=0.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Word match: an entry matches when its stored address equals ld_addr[31:2].
- Load result: when ld_en=1, ld_data is the data of the youngest matching valid entry, searched from tail-1 back to head. If no entry matches, ld_data=mem_RD. When ld_en=0, ld_data=0.
- Ordering: stores retire to memory strictly in FIFO order. Duplicate addresses are not coalesced.
- A store enqueued in the same cycle as a load is not visible to that load.
- empty = (count==0).

## Timing
- Reset asserted: count=0, head=tail=0, asynchronously. Outputs then read st_ready=1, empty=1, mem_WE=0, ld_stall=0, ld_data=0. Entry storage is not cleared.
- Reset asserted mid-operation: all pending stores are discarded, with no partial memory write.
- Store-to-memory latency: minimum 1 cycle. The entry drains in the cycle after enqueue if ld_en=0, and memory updates at the end of that cycle.
- Load latency: 0 cycles. ld_data is combinational from ld_addr, the buffer contents and mem_RD.
- Sustained throughput: one store per cycle with no loads. Each load cycle delays draining by one cycle.

## Configuration
- STORE_BUF_FWD_EN defined: forwarding as described above, and ld_stall is always 0.
- STORE_BUF_FWD_EN undefined: no forwarding path.
  - A load that matches any valid entry asserts ld_stall=1. The buffer then drains that cycle as if ld_en=0, and ld_data=0.
  - The stall repeats each cycle until no entry matches. The load then reads mem_RD with ld_stall=0.
  - Loads that match no entry behave identically in both builds.

## Structure
- Shared package holds:
  - the word-address slice width constant (30);
  - the entry struct {addr, data};
  - a clog2 helper for the pointer and count widths.
- One sub-module, store_buffer_match: combinational youngest-match search returning {hit, data}. It is instantiated whether or not STORE_BUF_FWD_EN is defined; without the macro only hit is used.
- The FIFO control and arbitration live in the top-level module.

## Test plan
- Reset, then 3 stores to 0x10, 0x14, 0x18 (data 0xA, 0xB, 0xC) with ld_en=0 → mem_WE pulses on 3 consecutive cycles, one cycle behind each store, with matching addr/data; empty=1 afterwards.
- 5 back-to-back stores, DEPTH=4, with ld_en held at 1 (address 0x100) → st_ready drops after the 4th enqueue and the 5th is held. Releasing ld_en drains 0x… entries in order, and the 5th store is accepted the cycle after the first drain.
- FWD build: stores 0x20←0x1111 then 0x20←0x2222 while memory holds 0x20=0x0, then load 0x22 → ld_data=0x2222 and ld_stall=0.
- Non-FWD build, same stimulus → ld_stall=1 until both entries are drained (2 cycles), then ld_data=0x2222 read from memory.
- Load from 0x40 while the buffer holds only 0x44 → ld_data=mem_RD and mem_WE=0 that cycle.
- Assert Reset with 3 pending entries → empty=1 and st_ready=1 immediately; subsequent loads from those addresses return the old memory contents.
